fifo_rd_stage: RTL and testbench
================================

# fifo_rd_stage

Read-side output stage of the asynchronous FIFO, in the clk_r domain. It sits directly downstream of the read-pointer handler and the dual-port memory read port. It turns the handler's `empty` flag and the memory's registered read data into a valid/ready stream. A 3-entry output buffer absorbs the 1-cycle memory read latency, so the stage sustains one word per cycle with no combinational path from `m_ready` to `r_en`.

## Interface
- DATA_WIDTH, 8, width of the FIFO word
- OUT_DEPTH, 3, output buffer entries; fixed at 3, other values unsupported
- clk_r  in  1  read-domain clock
- arst  in  1  reset: asynchronous, active-high
- flush  in  1  synchronous discard of buffered and in-flight words
- empty  in  1  registered empty flag from the read-pointer handler
- r_en  out  1  pop request to the read-pointer handler
- r_data  in  DATA_WIDTH  memory read data, valid the cycle after an accepted pop
- m_valid  out  1  output word available
- m_ready  in  1  downstream accepts
- m_data  out  DATA_WIDTH  head word of output buffer
- level  out  2  words currently held in output buffer (0..3)

## Operation
- State registers:
  - `cnt` (0..3): buffered words
  - `pend` (1 bit): read issued last cycle, data arriving this cycle
  - `head` and `tail` (2-bit, mod 3)
  - data array `buf[0..2]`
- Issue rule: `r_en = !arst && !flush && !empty && (cnt + pend < 3)`.
  - `r_en` depends only on registers and `empty`.
  - `m_ready` must never feed `r_en`.
- An accepted pop (`r_en` high at an edge) sets `pend` = 1 for the next cycle; otherwise `pend` = 0.
- Capture: when `pend` = 1 and `flush` = 0, `buf[tail] <= r_data`, then `tail` advances mod 3.
- Pop: when `m_valid && m_ready`, `head` advances mod 3.
- Count update: `cnt_next = cnt + (pend & !flush) - (m_valid & m_ready & !flush)`.
  - A simultaneous capture and pop leaves `cnt` unchanged.
- `m_valid = (cnt != 0)`, `m_data = buf[head]`, `level = cnt`.
- `m_data` holds stable while `m_valid && !m_ready`. Valid/ready protocol: `m_valid` is never withdrawn without a handshake, except by `flush` or `arst`.
- Overflow is impossible by construction. `cnt + pend` never exceeds 3; if it would, flag it as an assertion failure.
- `flush` (one cycle, sampled at the edge):
  - sets `cnt`, `pend`, `head`, `tail` to 0
  - drops the `r_data` of any in-flight read
  - forces `r_en` low that cycle
  - words already popped from the FIFO are lost; this is by design

## Timing
- Reset values: `cnt` = 0, `pend` = 0, `head` = `tail` = 0, `buf` = 0, so `m_valid` = 0, `m_data` = 0, `level` = 0. `r_en` = 0 while `arst` is high.
- Latency, with `empty` falling in cycle 0:
  - `r_en` high in cycle 0
  - `r_data` valid in cycle 1
  - `m_valid` high in cycle 2
- Throughput: with `m_ready` held high and `empty` low, `r_en` stays high every cycle and `m_valid` stays high every cycle after the first word arrives.
- Backpressure: with `m_ready` low, exactly 3 pops are accepted (`cnt` + `pend` reaches 3), then `r_en` stays low. When `m_ready` rises, `r_en` reasserts in the cycle after the first handshake.
- `empty` rising with `pend` = 1: the in-flight word is still captured; no further pops.
- `arst` mid-stream: all state clears immediately (asynchronous). The first `r_en` can follow the first `clk_r` edge after `arst` falls.

## Structure
- Shared package `fifo_pkg`:
  - DATA_WIDTH and PTR_WIDTH defaults
  - `OUT_DEPTH` = 3
  - a mod-3 increment function for `head`/`tail`
- One sub-module, `rd_out_buf`: 3-entry register array with `head`/`tail`/`cnt`, capture/pop/flush inputs, and `m_data`/`level` outputs.
- Issue logic and `pend` stay in `fifo_rd_stage`.
- The memory model lives only in the testbench.

## Test plan
- Reset, then `empty` = 1 for 10 cycles → `r_en` = 0, `m_valid` = 0, `level` = 0, `m_data` = 0 throughout.
- Load words 0x11, 0x22, 0x33, 0x44 with `m_ready` = 1 → `m_data` sequence is 0x11..0x44. `m_valid` is first high 2 cycles after `empty` falls and then stays high for 4 consecutive cycles.
- Load 6 words with `m_ready` = 0 → exactly 3 `r_en` pulses and `level` = 3. Raising `m_ready` yields all 6 words in order with no duplicates.
- `empty` rises in the same cycle a pop is pending → that word still appears on `m_data`; `r_en` stays low afterwards.
- `flush` while `level` = 2 and `pend` = 1 → next cycle `level` = 0, `m_valid` = 0. The in-flight word never appears; the next loaded word 0xA5 is output correctly.
- `arst` pulsed mid-stream with `level` = 3 → `m_valid`, `level`, `r_en` are 0 immediately. After release, streaming restarts from the next memory word.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the async FIFO read side.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PTR_WIDTH      = 2;
  localparam int OUT_DEPTH      = 3;

  // Advance a head/tail pointer around the 3-entry output buffer.
  function automatic logic [PTR_WIDTH-1:0] inc_mod3(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_WIDTH'(OUT_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rd_out_buf
//  Description : 3-entry circular output buffer with head/tail/count.
//                Captures memory read data, presents the head word.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_r,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] r_buf [OUT_DEPTH];
  logic [PTR_WIDTH-1:0]  r_head;
  logic [PTR_WIDTH-1:0]  r_tail;
  logic [1:0]            r_cnt;

  // Pointer and occupancy bookkeeping; flush empties the buffer logically.
  always_ff @(posedge clk_r or posedge arst) begin
    if (arst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (capture) r_tail <= inc_mod3(r_tail);
      if (pop)     r_head <= inc_mod3(r_head);
      r_cnt <= r_cnt + {1'b0, capture} - {1'b0, pop};
    end
  end

  // Word storage; stale contents survive flush since they are unreachable.
  always_ff @(posedge clk_r or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < OUT_DEPTH; i++) r_buf[i] <= '0;
    end else if (capture && !flush) begin
      r_buf[r_tail] <= wr_data;
    end
  end

  assign m_data = r_buf[r_head];
  assign level  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stage
//  Description : Read-side output stage of the async FIFO (clk_r domain).
//                Issues pops from registered state only and converts the
//                1-cycle-latency memory read into a valid/ready stream.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_stage #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF,
  parameter int OUT_DEPTH  = fifo_pkg::OUT_DEPTH      // only 3 is supported
) (
  input  logic                  clk_r,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level
);
  import fifo_pkg::*;

  logic       r_pend;
  logic [1:0] w_level;
  logic [2:0] w_occ;
  logic       w_capture;
  logic       w_pop;

  // Buffered words plus the one in flight; pops stop once every slot is spoken for,
  // so m_ready never reaches r_en combinationally.
  assign w_occ     = {1'b0, w_level} + {2'b00, r_pend};
  assign r_en      = !arst && !flush && !empty && (w_occ < 3'(OUT_DEPTH));
  assign m_valid   = (w_level != 2'd0);
  assign level     = w_level;
  assign w_capture = r_pend && !flush;
  assign w_pop     = m_valid && m_ready;

  // A pop accepted this edge means memory data arrives next cycle.
  always_ff @(posedge clk_r or posedge arst) begin
    if (arst) r_pend <= 1'b0;
    else      r_pend <= r_en;
  end

  rd_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk_r   (clk_r),
    .arst    (arst),
    .flush   (flush),
    .capture (w_capture),
    .wr_data (r_data),
    .pop     (w_pop),
    .m_data  (m_data),
    .level   (w_level)
  );

  a_no_overflow: assert property (@(posedge clk_r) disable iff (arst)
                                  w_occ <= 3'(OUT_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stage
//  Description : Self-checking bench for fifo_rd_stage with a queue-based
//                model of the output stage and a memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_rd_stage;

  logic       clk_r = 1'b0;
  logic       arst  = 1'b1;
  logic       flush = 1'b0;
  logic       empty = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       r_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] level;

  fifo_rd_stage #(.DATA_WIDTH(8), .OUT_DEPTH(3)) dut (
    .clk_r   (clk_r),
    .arst    (arst),
    .flush   (flush),
    .empty   (empty),
    .r_en    (r_en),
    .r_data  (r_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  always #5 clk_r = ~clk_r;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] q[$];          // words the stage holds, head first
  bit         infl = 1'b0;   // a memory read is in flight
  logic [7:0] infl_word = 8'h00;
  logic [7:0] mem_q[$];      // words ever written into the FIFO memory
  int         rd_ptr = 0;    // next memory word to be popped
  bit         loaded = 1'b0; // any word captured since reset
  bit         force_empty = 1'b1;
  int         ren_cnt = 0;
  int         vcnt = 0;
  logic [7:0] out_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ren();
    return !flush && !empty && ((q.size() + int'(infl)) < 3);
  endfunction

  // Reference model: advances at each active edge, then drives memory read data.
  initial begin
    bit ren;
    bit pop;
    forever begin
      @(posedge clk_r);
      if (arst) begin
        q.delete();
        infl = 1'b0;
        loaded = 1'b0;
      end else begin
        ren = exp_ren();
        pop = (q.size() != 0) && m_ready && !flush;
        if (flush) begin
          q.delete();
        end else begin
          if (pop) void'(q.pop_front());
          if (infl) begin
            q.push_back(infl_word);
            loaded = 1'b1;
          end
        end
        if (ren) begin
          infl = 1'b1;
          infl_word = mem_q[rd_ptr];
          rd_ptr++;
        end else begin
          infl = 1'b0;
        end
      end
      #1 r_data = infl ? infl_word : 8'($urandom);
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk_r) begin
    if (arst) begin
      chk("rst_r_en", {31'b0, r_en}, 0);
      chk("rst_m_valid", {31'b0, m_valid}, 0);
      chk("rst_level", {30'b0, level}, 0);
      chk("rst_m_data", {24'b0, m_data}, 0);
    end else begin
      chk("r_en", {31'b0, r_en}, {31'b0, exp_ren()});
      chk("m_valid", {31'b0, m_valid}, {31'b0, (q.size() != 0)});
      chk("level", {30'b0, level}, q.size());
      if (q.size() != 0)  chk("m_data", {24'b0, m_data}, {24'b0, q[0]});
      else if (!loaded)   chk("m_data_zero", {24'b0, m_data}, 0);
    end
    if (r_en) ren_cnt++;
    if (m_valid) vcnt++;
    if (m_valid && m_ready) out_log.push_back(m_data);
  end

  task automatic upd_empty();
    empty = force_empty || (mem_q.size() <= rd_ptr);
  endtask

  task automatic tick();
    @(posedge clk_r);
    #1;
    upd_empty();
  endtask

  task automatic wait_idle(input string name, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (q.size() == 0 && !infl && mem_q.size() <= rd_ptr) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(name, {31'b0, done}, 1);
  endtask

  logic [6:0] tp_ren = 7'b0001111;
  logic [6:0] tp_vld = 7'b0111100;
  logic [7:0] tp_dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    bit ok;
    // Reset, then idle with empty high.
    repeat (3) tick();
    arst = 1'b0;
    ren_cnt = 0; vcnt = 0;
    repeat (10) tick();
    chk("idle_ren_cnt", ren_cnt, 0);
    chk("idle_vcnt", vcnt, 0);

    // Streaming with m_ready high: fixed latency and throughput.
    for (int i = 0; i < 4; i++) mem_q.push_back(tp_dat[i]);
    out_log.delete();
    m_ready = 1'b1;
    force_empty = 1'b0;
    upd_empty();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_r);
      chk("tp_r_en", {31'b0, r_en}, {31'b0, tp_ren[k]});
      chk("tp_m_valid", {31'b0, m_valid}, {31'b0, tp_vld[k]});
      if (k >= 2 && k <= 5) chk("tp_m_data", {24'b0, m_data}, {24'b0, tp_dat[k-2]});
      tick();
    end
    chk("tp_count", out_log.size(), 4);

    // Backpressure: exactly three pops accepted, then drain in order.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) mem_q.push_back(8'h51 + 8'(i));
    upd_empty();
    ren_cnt = 0;
    repeat (8) tick();
    chk("bp_ren_cnt", ren_cnt, 3);
    @(negedge clk_r);
    chk("bp_level", {30'b0, level}, 3);
    tick();
    out_log.delete();
    m_ready = 1'b1;
    wait_idle("bp_drain_timeout", 40);
    repeat (2) tick();
    chk("bp_out_count", out_log.size(), 6);
    if (out_log.size() == 6)
      for (int i = 0; i < 6; i++) chk("bp_out_word", {24'b0, out_log[i]}, 32'h51 + i);

    // Empty rises while a read is in flight: the word still comes out.
    out_log.delete();
    ren_cnt = 0;
    mem_q.push_back(8'h77);
    upd_empty();
    wait_idle("er_timeout", 10);
    repeat (3) tick();
    chk("er_ren_cnt", ren_cnt, 1);
    chk("er_out_count", out_log.size(), 1);
    if (out_log.size() == 1) chk("er_out_word", {24'b0, out_log[0]}, 32'h77);

    // Flush with two words buffered and one in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) mem_q.push_back(8'h81 + 8'(i));
    upd_empty();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 2 && infl) begin ok = 1'b1; break; end
      tick();
    end
    chk("fl_reach", {31'b0, ok}, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_log.delete();
    mem_q.push_back(8'hA5);
    m_ready = 1'b1;
    upd_empty();
    @(negedge clk_r);
    chk("fl_level", {30'b0, level}, 0);
    chk("fl_m_valid", {31'b0, m_valid}, 0);
    wait_idle("fl_timeout", 10);
    repeat (2) tick();
    chk("fl_out_count", out_log.size(), 1);
    if (out_log.size() == 1) chk("fl_out_word", {24'b0, out_log[0]}, 32'hA5);

    // Asynchronous reset mid-stream with a full buffer.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) mem_q.push_back(8'h91 + 8'(i));
    upd_empty();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 3) begin ok = 1'b1; break; end
      tick();
    end
    chk("ar_reach", {31'b0, ok}, 1);
    #2 arst = 1'b1;
    q.delete(); infl = 1'b0; loaded = 1'b0;
    #1;
    chk("ar_m_valid", {31'b0, m_valid}, 0);
    chk("ar_level", {30'b0, level}, 0);
    chk("ar_r_en", {31'b0, r_en}, 0);
    tick(); tick();
    arst = 1'b0;
    out_log.delete();
    m_ready = 1'b1;
    wait_idle("ar_timeout", 10);
    repeat (2) tick();
    chk("ar_out_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("ar_out_w0", {24'b0, out_log[0]}, 32'h94);
      chk("ar_out_w1", {24'b0, out_log[1]}, 32'h95);
    end

    // Randomised traffic with backpressure, stalls and occasional flush.
    for (int n = 0; n < 600; n++) begin
      flush = ($urandom_range(0, 99) < 3);
      m_ready = ($urandom_range(0, 99) < 60);
      force_empty = ($urandom_range(0, 4) == 0);
      if (mem_q.size() - rd_ptr < 4) mem_q.push_back(8'($urandom));
      upd_empty();
      tick();
    end
    flush = 1'b0;
    force_empty = 1'b1;
    m_ready = 1'b1;
    upd_empty();
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
